// File: rtl/io_responder.sv
// rtl/io_responder.sv - IO bus responder: per-channel input holding registers and address-tagged output FIFO
// Optional error flags (ovf/udf/err_clr) are built when IO_RESPONDER_ERR_FLAGS_EN is defined.
module io_responder #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int OFIFOW = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [NUBITS-1:0]            io_in,
  input  logic [$clog2(NUIOIN)-1:0]    addr_in,
  input  logic                         req_in,
  input  logic [NUBITS-1:0]            data_out,
  input  logic [$clog2(NUIOOU)-1:0]    addr_out,
  input  logic                         out_en,
  input  logic [NUIOIN*NUBITS-1:0]     ext_in_data,
  input  logic [NUIOIN-1:0]            ext_in_valid,
  output logic [NUIOIN-1:0]            ext_in_ready,
  output logic [NUBITS-1:0]            ext_out_data,
  output logic [$clog2(NUIOOU)-1:0]    ext_out_addr,
  output logic                         ext_out_valid,
  input  logic                         ext_out_ready,
`ifdef IO_RESPONDER_ERR_FLAGS_EN
  output logic                         ovf,
  output logic                         udf,
  input  logic                         err_clr,
`endif
  output logic                         out_full
);

  localparam int AIW   = $clog2(NUIOIN);
  localparam int AOW   = $clog2(NUIOOU);
  localparam int DEPTH = 1 << OFIFOW;
  localparam int EW    = AOW + NUBITS;

  localparam logic [AIW:0]      NIN      = (AIW+1)'(NUIOIN);
  localparam logic [OFIFOW:0]   CNT_FULL = (OFIFOW+1)'(DEPTH);
  localparam logic [OFIFOW:0]   CNT_ONE  = (OFIFOW+1)'(1);
  localparam logic [OFIFOW-1:0] PTR_ONE  = OFIFOW'(1);

  // ---------------- input side ----------------
  logic [NUBITS-1:0] hreg [NUIOIN];
  logic [NUIOIN-1:0] hv;
  logic              in_range;
  logic              rd_hit;

  // channel select is only honoured for existing channels
  assign in_range     = ({1'b0, addr_in} < NIN);
  assign rd_hit       = req_in & in_range & hv[addr_in];
  assign ext_in_ready = ~hv;

  // read mux: stale value on empty channel, zero when out of range
  always_comb begin
    io_in = '0;
    if (in_range) io_in = hreg[addr_in];
  end

  // holding registers: producer load when empty, core read clears the valid flag only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUIOIN; i++) hreg[i] <= '0;
      hv <= '0;
    end else begin
      for (int i = 0; i < NUIOIN; i++) begin
        if (ext_in_valid[i] && !hv[i]) begin
          hreg[i] <= ext_in_data[i*NUBITS +: NUBITS];
          hv[i]   <= 1'b1;
        end else if (rd_hit && (addr_in == AIW'(i))) begin
          hv[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [EW-1:0]       mem [DEPTH];
  logic [OFIFOW-1:0]   rptr;
  logic [OFIFOW-1:0]   wptr;
  logic [OFIFOW:0]     count;
  logic [EW-1:0]       last;
  logic [EW-1:0]       head;
  logic                push;
  logic                pop;

  assign ext_out_valid = (count != '0);
  assign out_full      = (count == CNT_FULL);
  assign pop           = ext_out_valid & ext_out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still admits the push
  assign push          = out_en & (~out_full | pop);

  // when empty the port keeps showing the entry most recently handed out
  assign head = ext_out_valid ? mem[rptr] : last;
  assign {ext_out_addr, ext_out_data} = head;

  // storage array; contents are only observed through valid pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {addr_out, data_out};
  end

  // pointers, occupancy and last-popped entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) begin
        rptr <= rptr + PTR_ONE;
        last <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef IO_RESPONDER_ERR_FLAGS_EN
  logic drop;
  logic under;

  assign drop  = out_en & out_full & ~pop;
  assign under = req_in & ~(in_range & hv[addr_in]);

  // sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (under)        udf <= 1'b1;
      else if (err_clr) udf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - self-checking bench for io_responder with queue-based reference model
module tb_io_responder;

  localparam int NUBITS = 32;
  localparam int NUIOIN = 8;
  localparam int NUIOOU = 8;
  localparam int OFIFOW = 2;
  localparam int DEPTH  = 4;
  localparam int AIW    = 3;
  localparam int AOW    = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUBITS-1:0]        io_in;
  logic [AIW-1:0]           addr_in;
  logic                     req_in;
  logic [NUBITS-1:0]        data_out;
  logic [AOW-1:0]           addr_out;
  logic                     out_en;
  logic [NUIOIN*NUBITS-1:0] ext_in_data;
  logic [NUIOIN-1:0]        ext_in_valid;
  logic [NUIOIN-1:0]        ext_in_ready;
  logic [NUBITS-1:0]        ext_out_data;
  logic [AOW-1:0]           ext_out_addr;
  logic                     ext_out_valid;
  logic                     ext_out_ready;
  logic                     out_full;
`ifdef IO_RESPONDER_ERR_FLAGS_EN
  logic                     ovf;
  logic                     udf;
  logic                     err_clr;
`endif

  always #5 clk = ~clk;

  io_responder #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .OFIFOW(OFIFOW)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
    .data_out(data_out), .addr_out(addr_out), .out_en(out_en),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_addr(ext_out_addr), .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready),
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    .ovf(ovf), .udf(udf), .err_clr(err_clr),
`endif
    .out_full(out_full)
  );

  int checks = 0;
  int errors = 0;

  // reference model: plain arrays and a queue of {addr, data}
  logic [NUBITS-1:0]     m_hreg [NUIOIN];
  bit                    m_hv   [NUIOIN];
  logic [AOW+NUBITS-1:0] m_q [$];
  logic [AOW+NUBITS-1:0] m_last;
  bit                    m_ovf;
  bit                    m_udf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUIOIN; i++) begin
      m_hreg[i] = '0;
      m_hv[i]   = 1'b0;
    end
    m_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic idle();
    addr_in = '0; req_in = 1'b0; data_out = '0; addr_out = '0; out_en = 1'b0;
    ext_in_data = '0; ext_in_valid = '0; ext_out_ready = 1'b0;
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
  endtask

  task automatic set_word(input int ch, input logic [NUBITS-1:0] w);
    ext_in_data[ch*NUBITS +: NUBITS] = w;
  endtask

  // compare every output against the model, then advance the model and the clock one cycle
  task automatic step();
    logic [AOW+NUBITS-1:0] head;
    logic [NUBITS-1:0]     e_io;
    logic [NUIOIN-1:0]     e_rdy;
    bit                    e_valid, e_full, pop, push, hit;
    int                    a;
    #1;
    a       = int'(addr_in);
    e_io    = (a < NUIOIN) ? m_hreg[a] : '0;
    for (int i = 0; i < NUIOIN; i++) e_rdy[i] = !m_hv[i];
    e_valid = (m_q.size() != 0);
    e_full  = (m_q.size() == DEPTH);
    head    = e_valid ? m_q[0] : m_last;
    chk("io_in", io_in, e_io);
    chk("ext_in_ready", ext_in_ready, e_rdy);
    chk("ext_out_valid", ext_out_valid, e_valid);
    chk("out_full", out_full, e_full);
    chk("ext_out_data", ext_out_data, head[NUBITS-1:0]);
    chk("ext_out_addr", ext_out_addr, head[AOW+NUBITS-1:NUBITS]);
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
`endif
    pop  = e_valid && ext_out_ready;
    push = out_en && (!e_full || pop);
    hit  = req_in && (a < NUIOIN) && m_hv[a];
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    if (out_en && e_full && !pop) m_ovf = 1'b1;
    else if (err_clr)             m_ovf = 1'b0;
    if (req_in && !hit)           m_udf = 1'b1;
    else if (err_clr)             m_udf = 1'b0;
`endif
    for (int i = 0; i < NUIOIN; i++) begin
      if (ext_in_valid[i] && !m_hv[i]) begin
        m_hreg[i] = ext_in_data[i*NUBITS +: NUBITS];
        m_hv[i]   = 1'b1;
      end
    end
    if (hit) m_hv[a] = 1'b0;
    if (pop)  m_last = m_q.pop_front();
    if (push) m_q.push_back({addr_out, data_out});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_d [4];
    idle();
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_io_in", io_in, 0);
    chk("rst_ready", ext_in_ready, 8'hFF);
    chk("rst_valid", ext_out_valid, 0);
    chk("rst_full", out_full, 0);
    chk("rst_data", ext_out_data, 0);
    chk("rst_addr", ext_out_addr, 0);
    rst = 1'b1;
    step();

    // single word on channel 3
    set_word(3, 32'h0000_00A5);
    ext_in_valid = 8'h08;
    step();
    ext_in_valid = '0;
    addr_in = 3;
    #1;
    chk("ch3_ready_low", ext_in_ready[3], 0);
    chk("ch3_io_in", io_in, 32'hA5);
    chk("ch3_model", m_hreg[3], 32'hA5);
    step();
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    #1;
    chk("ch3_ready_back", ext_in_ready[3], 1);
    step();

    // five writes into a four-deep FIFO, then drain
    for (int k = 0; k < 5; k++) begin
      out_en = 1'b1; addr_out = AOW'(k); data_out = 10 + k;
      step();
      if (k == 3) begin
        #1;
        chk("full_after_4", out_full, 1);
      end
    end
    out_en = 1'b0;
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    #1;
    chk("ovf_after_drop", ovf, 1);
`endif
    ext_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_addr", ext_out_addr, k);
      chk("drain_data", ext_out_data, 10 + k);
      step();
    end
    ext_out_ready = 1'b0;
    #1;
    chk("drained_valid", ext_out_valid, 0);
    chk("drained_last", ext_out_data, 13);
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
`endif
    step();

    // full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      out_en = 1'b1; addr_out = AOW'(k); data_out = 20 + k;
      step();
    end
    ext_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_out = AOW'(4 + k); data_out = 30 + k;
      #1;
      chk("pp_full", out_full, 1);
      step();
    end
    out_en = 1'b0;
    exp_d = '{23, 30, 31, 32};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pp_order", ext_out_data, exp_d[k]);
      step();
    end
    ext_out_ready = 1'b0;
    step();

    // read of an empty channel returns the stale word
    set_word(5, 32'h77);
    ext_in_valid = 8'h20;
    step();
    ext_in_valid = '0;
    addr_in = 5; req_in = 1'b1;
    step();
    #1;
    chk("empty_io_in", io_in, 32'h77);
    chk("empty_ready", ext_in_ready[5], 1);
    step();
    req_in = 1'b0;
`ifdef IO_RESPONDER_ERR_FLAGS_EN
    #1;
    chk("udf_set", udf, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1;
    chk("udf_cleared", udf, 0);
`endif
    step();

    // asynchronous reset in the middle of a drain
    set_word(0, 32'h1234);
    ext_in_valid = 8'h01;
    for (int k = 0; k < 3; k++) begin
      out_en = 1'b1; addr_out = AOW'(k + 1); data_out = 40 + k;
      step();
      ext_in_valid = '0;
    end
    out_en = 1'b0; ext_out_ready = 1'b1; addr_in = 0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", ext_out_valid, 0);
    chk("mid_rst_ready", ext_in_ready, 8'hFF);
    chk("mid_rst_io_in", io_in, 0);
    chk("mid_rst_data", ext_out_data, 0);
    model_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    out_en = 1'b1; addr_out = 6; data_out = 32'h99;
    step();
    out_en = 1'b0;
    #1;
    chk("post_rst_valid", ext_out_valid, 1);
    chk("post_rst_addr", ext_out_addr, 6);
    chk("post_rst_data", ext_out_data, 32'h99);
    ext_out_ready = 1'b1;
    step();
    ext_out_ready = 1'b0;

    // channels 0 and 7 loaded together, read back to back
    set_word(0, 32'hC0C0_0000);
    set_word(7, 32'h0000_C7C7);
    ext_in_valid = 8'h81;
    step();
    ext_in_valid = '0;
    addr_in = 0; req_in = 1'b1;
    #1;
    chk("b2b_ch0", io_in, 32'hC0C0_0000);
    step();
    addr_in = 7;
    #1;
    chk("b2b_ch7", io_in, 32'h0000_C7C7);
    step();
    req_in = 1'b0;
    #1;
    chk("b2b_hv_clear", ext_in_ready, 8'hFF);
    step();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUIOIN; i++) set_word(i, $urandom);
      ext_in_valid  = NUIOIN'($urandom);
      addr_in       = AIW'($urandom);
      req_in        = ($urandom_range(0, 1) == 1);
      out_en        = ($urandom_range(0, 2) != 0);
      addr_out      = AOW'($urandom);
      data_out      = $urandom;
      ext_out_ready = ($urandom_range(0, 2) != 0);
`ifdef IO_RESPONDER_ERR_FLAGS_EN
      err_clr       = ($urandom_range(0, 7) == 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Peripheral-side responder for the processor core's IO bus. It serves core reads (`req_in`/`addr_in` -> `io_in`) from per-channel input holding registers filled by external producers over valid/ready.
- It captures core writes (`out_en`/`addr_out`/`data_out`) into an address-tagged output FIFO drained by an external consumer over valid/ready.
- Sits between the core's IO pins and board-level peripherals.

Parameters:
- NUBITS, 32, data word width; matches the core.
- NUIOIN, 8, number of input channels; must be >= 2.
- NUIOOU, 8, number of output addresses; must be >= 2.
- OFIFOW, 2, log2 of output FIFO depth; depth = 2^OFIFOW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- io_in  output  NUBITS  read data to the core.
- addr_in  input  $clog2(NUIOIN)  core input channel select.
- req_in  input  1  core read strobe; one read per cycle it is high.
- data_out  input  NUBITS  core write data.
- addr_out  input  $clog2(NUIOOU)  core write address.
- out_en  input  1  core write strobe.
- ext_in_data  input  NUIOIN*NUBITS  producer words; channel i occupies bits [i*NUBITS +: NUBITS].
- ext_in_valid  input  NUIOIN  per-channel producer valid.
- ext_in_ready  output  NUIOIN  per-channel holding register empty.
- ext_out_data  output  NUBITS  FIFO head data.
- ext_out_addr  output  $clog2(NUIOOU)  FIFO head address tag.
- ext_out_valid  output  1  FIFO non-empty.
- ext_out_ready  input  1  consumer accepts head.
- out_full  output  1  FIFO holds 2^OFIFOW entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - All holding registers hreg[i] = 0 and flags hv[i] = 0.
  - FIFO read/write pointers and count = 0.
  - Outputs: io_in = 0, ext_in_ready = all 1, ext_out_valid = 0, out_full = 0, ext_out_data = 0, ext_out_addr = 0.
  - Reset mid-operation discards all buffered words; no partial transfer survives.
- Input channel i:
  - ext_in_ready[i] = ~hv[i], derived from registered state only.
  - On an edge with ext_in_valid[i] & ext_in_ready[i]: hreg[i] <= word, hv[i] <= 1.
  - On an edge with req_in & (addr_in == i) & hv[i]: hv[i] <= 0; hreg[i] keeps its value.
  - Load and consume cannot coincide on the same channel, because ready = ~hv.
- io_in = hreg[addr_in], combinational from registered state.
  - A word accepted at edge N is visible on io_in from cycle N+1.
  - Reading an empty channel (req_in with hv = 0) returns the stale hreg value with no state change.
  - An out-of-range addr_in (>= NUIOIN) returns 0 and consumes nothing.
- Output FIFO:
  - Entries are {addr_out, data_out}.
  - Push: on an edge with out_en & (~out_full | pop).
  - Pop: on an edge with ext_out_valid & ext_out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance. When full, a same-cycle pop admits the push.
  - Push with out_full = 1 and no pop: the write is dropped, state unchanged.
  - Pointers wrap modulo 2^OFIFOW; count has OFIFOW+1 bits.
  - ext_out_valid = (count != 0). ext_out_data/ext_out_addr show the head entry and hold stable while valid & ~ready.
  - No bypass: a push into an empty FIFO at edge N asserts ext_out_valid from cycle N+1.
  - out_full = (count == 2^OFIFOW), registered-state derived.
  - When empty, ext_out_data/ext_out_addr show the last-popped entry, or 0 after reset.

Optional Feature:
- Macro IO_RESPONDER_ERR_FLAGS_EN.
- When defined, adds three ports:
  - ovf  output  1: sticky, set on the edge where a push is dropped.
  - udf  output  1: sticky, set on the edge where req_in reads an empty or out-of-range channel.
  - err_clr  input  1: synchronous clear of both flags. A same-cycle set wins over clear.
  - Both flags reset to 0.
- When undefined, these ports are absent and drops/underflows are silent; all other behaviour is identical.

Test Plan:
- Reset release, then ext_in_valid[3]=1 with word 32'h0000_00A5 -> ext_in_ready[3]=0 next cycle. With addr_in=3, io_in=32'hA5. A req_in pulse restores ext_in_ready[3]=1.
- Write 5 words with out_en (addr_out = 0..4, data = 10..14) and ext_out_ready=0, OFIFOW=2 -> out_full=1 after the 4th write, 5th dropped (ovf=1 with macro). Then ready=1 drains tags 0..3 with data 10..13 in order, and ext_out_valid drops after the 4th pop.
- FIFO full with out_en and ext_out_ready both high for 3 cycles -> count stays 4, out_full stays 1, and the pushed words emerge in order after the existing ones.
- req_in on empty channel 5 with hreg[5] = 32'h77 from an earlier read -> io_in=32'h77, ext_in_ready[5] stays 1, udf=1 with macro; err_clr clears it the next cycle.
- Assert rst=0 mid-drain with 2 entries queued and hv[0]=1 -> immediately ext_out_valid=0, ext_in_ready=all 1, io_in=0. After release, new pushes start from a clean FIFO.
- Channels 0 and 7 loaded in the same cycle and read back to back (addr_in 0 then 7, req_in high 2 cycles) -> correct words on io_in each cycle; both hv cleared.
